// File: rtl/rns_to_binary_seq.sv
// Sequential 3-channel RNS-to-binary converter using mixed-radix conversion.
// Modular inverses are found by a run-time linear search, so any coprime moduli set works.
module rns_to_binary_seq #(
  parameter int unsigned RW = 3,
  parameter int unsigned OW = 3 * RW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] residue1,
  input  logic [RW-1:0] residue2,
  input  logic [RW-1:0] residue3,
  input  logic [RW-1:0] moduli1,
  input  logic [RW-1:0] moduli2,
  input  logic [RW-1:0] moduli3,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] binary,
  output logic [OW-1:0] range_m,
  output logic          err
);

  localparam int unsigned PW = 2 * RW;

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_INV12, S_INV13, S_INV23, S_DIG2, S_DIG3, S_ACCUM, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] r1_q, r2_q, r3_q, m1_q, m2_q, m3_q;
  logic [RW-1:0] r1_d, r2_d, r3_d, m1_d, m2_d, m3_d;
  logic [RW-1:0] k_q, k_d, i12_q, i12_d, i13_q, i13_d, i23_q, i23_d;
  logic [RW-1:0] v2_q, v2_d, v3_q, v3_d;
  logic [OW-1:0] bin_q, bin_d, rng_q, rng_d;
  logic          err_q, err_d;

  logic [RW-1:0] ma, mb;
  logic          hit;
  logic [PW-1:0] t3, u3;

  function automatic logic [PW-1:0] mod_mul(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                            input logic [PW-1:0] m);
    return (a * b) % m;
  endfunction

  function automatic logic [PW-1:0] mod_sub(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                            input logic [PW-1:0] m);
    return (a + m - (b % m)) % m;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r1_q    <= '0;
      r2_q    <= '0;
      r3_q    <= '0;
      m1_q    <= '0;
      m2_q    <= '0;
      m3_q    <= '0;
      k_q     <= '0;
      i12_q   <= '0;
      i13_q   <= '0;
      i23_q   <= '0;
      v2_q    <= '0;
      v3_q    <= '0;
      bin_q   <= '0;
      rng_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      r3_q    <= r3_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      m3_q    <= m3_d;
      k_q     <= k_d;
      i12_q   <= i12_d;
      i13_q   <= i13_d;
      i23_q   <= i23_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      bin_q   <= bin_d;
      rng_q   <= rng_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    r3_d    = r3_q;
    m1_d    = m1_q;
    m2_d    = m2_q;
    m3_d    = m3_q;
    k_d     = k_q;
    i12_d   = i12_q;
    i13_d   = i13_q;
    i23_d   = i23_q;
    v2_d    = v2_q;
    v3_d    = v3_q;
    bin_d   = bin_q;
    rng_d   = rng_q;
    err_d   = err_q;
    ma      = m1_q;
    mb      = m2_q;
    hit     = 1'b0;
    t3      = '0;
    u3      = '0;

    unique case (state_q)
      S_INV13: begin ma = m1_q; mb = m3_q; end
      S_INV23: begin ma = m2_q; mb = m3_q; end
      default: begin ma = m1_q; mb = m2_q; end
    endcase

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          r1_d    = residue1;
          r2_d    = residue2;
          r3_d    = residue3;
          m1_d    = moduli1;
          m2_d    = moduli2;
          m3_d    = moduli3;
          err_d   = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        k_d = RW'(1);
        // Error paths route through ACCUM so outputs are zeroed in one place.
        if ((m1_q < RW'(2)) || (m2_q < RW'(2)) || (m3_q < RW'(2)) ||
            (r1_q >= m1_q) || (r2_q >= m2_q) || (r3_q >= m3_q)) begin
          err_d   = 1'b1;
          state_d = S_ACCUM;
        end else begin
          state_d = S_INV12;
        end
      end
      S_INV12, S_INV13, S_INV23: begin
        hit = (mod_mul(PW'(ma), PW'(k_q), PW'(mb)) == PW'(1));
        if (hit) begin
          k_d = RW'(1);
          if (state_q == S_INV12) begin
            i12_d   = k_q;
            state_d = S_INV13;
          end else if (state_q == S_INV13) begin
            i13_d   = k_q;
            state_d = S_INV23;
          end else begin
            i23_d   = k_q;
            state_d = S_DIG2;
          end
        end else if (k_q >= (mb - RW'(1))) begin
          err_d   = 1'b1;
          state_d = S_ACCUM;
        end else begin
          k_d = k_q + RW'(1);
        end
      end
      S_DIG2: begin
        v2_d    = RW'(mod_mul(mod_sub(PW'(r2_q), PW'(r1_q), PW'(m2_q)), PW'(i12_q), PW'(m2_q)));
        state_d = S_DIG3;
      end
      S_DIG3: begin
        t3      = mod_mul(mod_sub(PW'(r3_q), PW'(r1_q), PW'(m3_q)), PW'(i13_q), PW'(m3_q));
        u3      = mod_sub(t3, PW'(v2_q), PW'(m3_q));
        v3_d    = RW'(mod_mul(u3, PW'(i23_q), PW'(m3_q)));
        state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (err_q) begin
          bin_d = '0;
          rng_d = '0;
        end else begin
          bin_d = OW'(r1_q) + OW'(m1_q) * OW'(v2_q) + OW'(m1_q) * OW'(m2_q) * OW'(v3_q);
          rng_d = OW'(m1_q) * OW'(m2_q) * OW'(m3_q);
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign binary    = bin_q;
  assign range_m   = rng_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rns_to_binary_seq.sv
// Directed self-checking bench for rns_to_binary_seq with hand-computed MRC results.
module tb_rns_to_binary_seq;

  logic       clk, rst_n, in_valid, in_ready, out_valid, out_ready, err;
  logic [2:0] residue1, residue2, residue3, moduli1, moduli2, moduli3;
  logic [8:0] binary, range_m;
  int checks, failures, lat, seen;

  rns_to_binary_seq #(.RW(3), .OW(9)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .residue1(residue1), .residue2(residue2), .residue3(residue3),
    .moduli1(moduli1), .moduli2(moduli2), .moduli3(moduli3),
    .out_valid(out_valid), .out_ready(out_ready),
    .binary(binary), .range_m(range_m), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one word, return edges from accept to out_valid; a garbage in_valid pulse while busy must be ignored.
  task automatic run(input logic [2:0] m1, m2, m3, r1, r2, r3, output int cycles);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    moduli1 = m1; moduli2 = m2; moduli3 = m3;
    residue1 = r1; residue2 = r2; residue3 = r3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    residue1 = 3'd7; residue2 = 3'd7; residue3 = 3'd7;
    moduli1 = 3'd1; moduli2 = 3'd1; moduli3 = 3'd1;
    cycles = 0;
    while (cycles < 300) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == 1) in_valid = 1'b0;
      if (out_valid) break;
    end
    in_valid = 1'b0;
    if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic after_handshake(input string tag);
    @(posedge clk); #1;
    check({tag, "_out_valid_dropped"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    residue1 = '0; residue2 = '0; residue3 = '0;
    moduli1 = '0; moduli2 = '0; moduli3 = '0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_binary", 32'(binary), 32'd0);
    check("rst_range_m", 32'(range_m), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // 3,5,7 / 2,3,2: i12=2 i13=5 i23=3
    run(3'd3, 3'd5, 3'd7, 3'd2, 3'd3, 3'd2, lat);
    check("t1_latency", 32'(lat), 32'd14);
    check("t1_binary", 32'(binary), 32'd23);
    check("t1_range_m", 32'(range_m), 32'd105);
    check("t1_err", 32'(err), 32'd0);
    check("t1_in_ready_busy", 32'(in_ready), 32'd0);
    after_handshake("t1");

    // 5,6,7 / 4,5,6: X = M-1, i12=5 i13=3 i23=6
    run(3'd5, 3'd6, 3'd7, 3'd4, 3'd5, 3'd6, lat);
    check("t2_latency", 32'(lat), 32'd18);
    check("t2_binary", 32'(binary), 32'd209);
    check("t2_range_m", 32'(range_m), 32'd210);
    check("t2_err", 32'(err), 32'd0);
    after_handshake("t2");

    // All-zero residues give X = 0 without error
    run(3'd3, 3'd5, 3'd7, 3'd0, 3'd0, 3'd0, lat);
    check("t3_latency", 32'(lat), 32'd14);
    check("t3_binary", 32'(binary), 32'd0);
    check("t3_err", 32'(err), 32'd0);
    after_handshake("t3");

    // Residue out of range: r1=5 >= m1=5
    run(3'd5, 3'd3, 3'd7, 3'd5, 3'd1, 3'd1, lat);
    check("t4_latency", 32'(lat), 32'd2);
    check("t4_err", 32'(err), 32'd1);
    check("t4_binary", 32'(binary), 32'd0);
    check("t4_range_m", 32'(range_m), 32'd0);
    after_handshake("t4");

    // Modulus below 2
    run(3'd1, 3'd5, 3'd7, 3'd0, 3'd0, 3'd0, lat);
    check("t5_latency", 32'(lat), 32'd2);
    check("t5_err", 32'(err), 32'd1);
    after_handshake("t5");

    // 2 and 4 not coprime: INV12 scans k=1..3
    run(3'd2, 3'd4, 3'd7, 3'd1, 3'd1, 3'd1, lat);
    check("t6_latency", 32'(lat), 32'd5);
    check("t6_err", 32'(err), 32'd1);
    check("t6_binary", 32'(binary), 32'd0);
    check("t6_range_m", 32'(range_m), 32'd0);
    after_handshake("t6");

    // Back-pressure: result must hold for 10 cycles
    out_ready = 1'b0;
    run(3'd3, 3'd5, 3'd7, 3'd2, 3'd3, 3'd2, lat);
    check("t7_latency", 32'(lat), 32'd14);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("t7_hold_out_valid", 32'(out_valid), 32'd1);
      check("t7_hold_binary", 32'(binary), 32'd23);
      check("t7_hold_range_m", 32'(range_m), 32'd105);
      check("t7_hold_err", 32'(err), 32'd0);
      check("t7_hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    after_handshake("t7");

    // Reset while in INV13 aborts the word
    moduli1 = 3'd3; moduli2 = 3'd5; moduli3 = 3'd7;
    residue1 = 3'd2; residue2 = 3'd3; residue3 = 3'd2;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t8_rst_binary", 32'(binary), 32'd0);
    check("t8_rst_range_m", 32'(range_m), 32'd0);
    check("t8_rst_out_valid", 32'(out_valid), 32'd0);
    check("t8_rst_in_ready", 32'(in_ready), 32'd1);
    check("t8_rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("t8_no_out_valid_after_abort", 32'(seen), 32'd0);
    run(3'd3, 3'd5, 3'd7, 3'd2, 3'd3, 3'd2, lat);
    check("t8_latency", 32'(lat), 32'd14);
    check("t8_binary", 32'(binary), 32'd23);
    check("t8_range_m", 32'(range_m), 32'd105);
    after_handshake("t8");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
